// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and types for the VGA output path and the line-buffer reader.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t hcnt;
        cnt_t vcnt;
        logic active;
        logic hs_raw;
        logic vs_raw;
    } timing_t;

    function automatic logic in_range(input cnt_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters plus unregistered active/sync decode for the VGA timing generator.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP
) (
    input  logic    clk,
    input  logic    areset,
    output timing_t tm
);

    localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HSS = H_VISIBLE + H_FP;
    localparam int VSS = V_VISIBLE + V_FP;

    cnt_t hcnt_q, hcnt_d;
    cnt_t vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + cnt_t'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == cnt_t'(HT - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == cnt_t'(VT - 1)) ? '0 : vcnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        tm.hcnt   = hcnt_q;
        tm.vcnt   = vcnt_q;
        tm.active = (hcnt_q < cnt_t'(H_VISIBLE)) && (vcnt_q < cnt_t'(V_VISIBLE));
        tm.hs_raw = in_range(hcnt_q, HSS, HSS + H_SYNC - 1);
        tm.vs_raw = in_range(vcnt_q, VSS, VSS + V_SYNC - 1);
    end

endmodule

// File: rtl/vga_640x480.sv
// VGA timing generator and pixel output stage: registered sync/RGB pins plus line/frame prefetch pulses.
module vga_640x480
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int   H_FP      = vga_timing_pkg::H_FP,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BP      = vga_timing_pkg::H_BP,
    parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int   V_FP      = vga_timing_pkg::V_FP,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BP      = vga_timing_pkg::V_BP,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [11:0] rgb_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        line_sync,
    output logic        frame_sync
);

    localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    timing_t tm;

    vga_sync_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_cnt (
        .clk    (clk),
        .areset (areset),
        .tm     (tm)
    );

    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        line_sync_q, line_sync_d;
    logic        frame_sync_q, frame_sync_d;
    logic        frame_valid_q, frame_valid_d;

    always_comb begin
        // Requests go out at the start of h-blank for the line that follows, so the
        // reader has the whole blanking interval to fill the buffer.
        line_sync_d   = (tm.hcnt == cnt_t'(H_VISIBLE)) &&
                        ((tm.vcnt == cnt_t'(VT - 1)) || (tm.vcnt < cnt_t'(V_VISIBLE - 1)));
        frame_sync_d  = (tm.hcnt == cnt_t'(H_VISIBLE)) && (tm.vcnt == cnt_t'(V_VISIBLE));
        frame_valid_d = frame_valid_q | frame_sync_d;
        rgb_d         = (tm.active && frame_valid_q) ? rgb_in : 12'h000;
        hs_d          = tm.hs_raw ? SYNC_POL : ~SYNC_POL;
        vs_d          = tm.vs_raw ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rgb_q         <= 12'h000;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            line_sync_q   <= 1'b0;
            frame_sync_q  <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_sync_q   <= line_sync_d;
            frame_sync_q  <= frame_sync_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign line_sync  = line_sync_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_vga_640x480.sv
// Bench for vga_640x480 on a scaled-down raster so several whole frames fit in a short run.
module tb_vga_640x480;

    localparam int HV = 40, HF = 4, HSW = 12, HB = 8;
    localparam int VV = 30, VF = 3, VSW = 2,  VB = 5;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        areset;
    logic [11:0] rgb_in;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, line_sync, frame_sync;

    vga_640x480 #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .SYNC_POL  (1'b0)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .rgb_in     (rgb_in),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .line_sync  (line_sync),
        .frame_sync (frame_sync)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: raster position since counting restarted, and whether a frame start was seen.
    int pos = 0;
    bit fv  = 1'b0;
    int cyc = 0;

    // Measurements taken from the pins.
    bit hs_prev = 1'b1, vs_prev = 1'b1;
    bit have_hf = 1'b0, have_vf = 1'b0, have_fs = 1'b0, have_ls = 1'b0;
    int hf_cyc, vf_cyc, fs_cyc, ls_cyc;
    int ls_cnt, fs_cnt;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pins();
        return {vga_r, vga_g, vga_b, vga_hs, vga_vs, line_sync, frame_sync};
    endfunction

    task automatic clear_meas();
        hs_prev = 1'b1; vs_prev = 1'b1;
        have_hf = 1'b0; have_vf = 1'b0; have_fs = 1'b0; have_ls = 1'b0;
    endtask

    // One pixel clock: drive rgb, predict the pins from the raster rules, compare, update timing measurements.
    task automatic tick(input logic [11:0] rgb);
        int h, v;
        bit act, first_px;
        logic [15:0] exp;
        rgb_in = rgb;
        @(posedge clk);
        h   = pos % HT;
        v   = (pos / HT) % VT;
        act = (h < HV) && (v < VV);
        exp[15:4] = (act && fv) ? rgb : 12'h000;
        exp[3]    = (h >= HV + HF && h < HV + HF + HSW) ? 1'b0 : 1'b1;
        exp[2]    = (v >= VV + VF && v < VV + VF + VSW) ? 1'b0 : 1'b1;
        exp[1]    = (h == HV) && (v == VT - 1 || v < VV - 1);
        exp[0]    = (h == HV) && (v == VV);
        first_px  = (h == 0) && (v == 0) && fv;
        if (exp[0]) fv = 1'b1;
        pos++;
        cyc++;
        #1;
        check16("pins", pins(), exp);

        if (hs_prev && !vga_hs) begin
            if (have_hf) check_int("hs_period", cyc - hf_cyc, HT);
            hf_cyc = cyc; have_hf = 1'b1;
        end
        if (!hs_prev && vga_hs && have_hf) check_int("hs_low_width", cyc - hf_cyc, HSW);
        if (vs_prev && !vga_vs) begin
            if (have_vf) check_int("vs_period", cyc - vf_cyc, FR);
            vf_cyc = cyc; have_vf = 1'b1;
        end
        if (!vs_prev && vga_vs && have_vf) check_int("vs_low_width", cyc - vf_cyc, VSW * HT);
        hs_prev = vga_hs;
        vs_prev = vga_vs;

        if (frame_sync) begin
            fs_cnt++;
            fs_cyc = cyc; have_fs = 1'b1;
        end
        if (line_sync) begin
            ls_cnt++;
            if (have_fs) check_int("fs_to_ls_gap", cyc - fs_cyc, (VT - 1 - VV) * HT);
            have_fs = 1'b0;
            ls_cyc = cyc; have_ls = 1'b1;
        end
        if (first_px && have_ls) check_int("line0_align", cyc - ls_cyc, HT - HV);
    endtask

    initial begin
        areset = 1'b1;
        rgb_in = 12'hFFF;

        // Held reset: pins idle at inactive sync, no pulses, black.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check16("reset_hold", pins(), 16'h000C);
        end
        areset = 1'b0;
        pos = 0; fv = 1'b0;

        // First frame after reset is blank even with a white source.
        for (int i = 0; i < FR; i++) tick(12'hFFF);

        // Two free-running frames with random pixels; pulse counts per frame.
        for (int f = 0; f < 2; f++) begin
            ls_cnt = 0; fs_cnt = 0;
            for (int i = 0; i < FR; i++) tick(12'($urandom));
            check_int("line_sync_count", ls_cnt, VV);
            check_int("frame_sync_count", fs_cnt, 1);
        end

        // Constant colour in the visible span, junk elsewhere that must be blanked.
        for (int i = 0; i < FR; i++) begin
            if ((pos % HT) < HV) tick(12'hA5C);
            else                 tick(12'($urandom));
        end

        // Reset in the middle of line 20.
        for (int i = 0; i < 20 * HT + 5; i++) tick(12'($urandom));
        areset = 1'b1;
        #1;
        check16("reset_async", pins(), 16'h000C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check16("reset_mid", pins(), 16'h000C);
        end
        areset = 1'b0;
        pos = 0; fv = 1'b0;
        clear_meas();

        // Restart from (0,0), blank until the next frame start, then live pixels again.
        ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < FR; i++) tick(12'($urandom_range(1, 4095)));
        check_int("restart_fs_count", fs_cnt, 1);
        for (int i = 0; i < FR / 2; i++) tick(12'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
